// File: rtl/trial_div_ctrl_pkg.sv
// trial_div_ctrl_pkg: shared widths, limits and FSM state encoding for the trial-division factoriser.
package trial_div_ctrl_pkg;
    localparam int N_W_DEF = 32;
    localparam int D_W_DEF = 16;
    localparam int MIN_N   = 4;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DIVIDE = 3'd2,
        S_CHECK  = 3'd3,
        S_FINISH = 3'd4
    } state_e;
endpackage

// File: rtl/trial_div_ctrl_div_core.sv
// sub_div_core: repeated-subtraction unsigned divider, one subtraction per cycle.
module sub_div_core #(
    parameter int N_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic [N_W-1:0] d,
    output logic [N_W-1:0] quotient,
    output logic [N_W-1:0] remainder,
    output logic           done
);
    logic           busy_q;
    logic [N_W-1:0] rem_q, quo_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            rem_q  <= n;
            quo_q  <= '0;
        end else if (busy_q) begin
            if (rem_q >= d) begin
                rem_q <= rem_q - d;
                quo_q <= quo_q + 1'b1;
            end else begin
                busy_q <= 1'b0;
            end
        end
    end
    // Result registers hold after done so the controller can read them in CHECK.
    assign done      = busy_q && (rem_q < d);
    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/trial_div_ctrl.sv
// trial_div_ctrl: finds the smallest proper divisor of n not above d_max by ascending trial division.
module trial_div_ctrl
    import trial_div_ctrl_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic [D_W-1:0] d_max,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [D_W-1:0] factor,
    output logic [N_W-1:0] cofactor
);
    state_e         state_q, state_d;
    logic [N_W-1:0] n_q, n_d, cof_q, cof_d, quo, rem;
    logic [D_W-1:0] dmax_q, dmax_d, fac_q, fac_d;
    // One extra bit so d_max = 2^D_W-1 can be exceeded without wrapping.
    logic [D_W:0]   d_q, d_d, d_inc;
    logic           found_q, found_d, core_start, core_done, stop;
    sub_div_core #(.N_W(N_W)) u_core (
        .clk       (clk),
        .reset     (reset),
        .start     (core_start),
        .n         (n_q),
        .d         (N_W'(d_q)),
        .quotient  (quo),
        .remainder (rem),
        .done      (core_done)
    );
    always_comb begin
        d_inc      = d_q + 1'b1;
        stop       = (d_inc > {1'b0, dmax_q}) || (N_W'(d_inc) >= n_q);
        state_d    = state_q;
        n_d        = n_q;
        dmax_d     = dmax_q;
        d_d        = d_q;
        found_d    = found_q;
        fac_d      = fac_q;
        cof_d      = cof_q;
        core_start = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                n_d     = n;
                dmax_d  = d_max;
                found_d = 1'b0;
                fac_d   = '0;
                cof_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: if (n_q < N_W'(MIN_N) || dmax_q < D_W'(2)) begin
                state_d = S_FINISH;
            end else begin
                d_d        = (D_W+1)'(2);
                core_start = 1'b1;
                state_d    = S_DIVIDE;
            end
            S_DIVIDE: state_d = core_done ? S_CHECK : S_DIVIDE;
            S_CHECK: if (rem == '0) begin
                found_d = 1'b1;
                fac_d   = d_q[D_W-1:0];
                cof_d   = quo;
                state_d = S_FINISH;
            end else begin
                d_d        = d_inc;
                core_start = !stop;
                state_d    = stop ? S_FINISH : S_DIVIDE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            dmax_q  <= '0;
            d_q     <= '0;
            found_q <= 1'b0;
            fac_q   <= '0;
            cof_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            dmax_q  <= dmax_d;
            d_q     <= d_d;
            found_q <= found_d;
            fac_q   <= fac_d;
            cof_q   <= cof_d;
        end
    end
    assign busy     = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done     = state_q == S_FINISH;
    assign found    = found_q;
    assign factor   = fac_q;
    assign cofactor = cof_q;
endmodule

// File: tb/tb_trial_div_ctrl.sv
// tb_trial_div_ctrl: directed vectors with hand-computed results for trial_div_ctrl.
module tb_trial_div_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, busy, done, found;
    logic [31:0] n, cofactor;
    logic [15:0] d_max, factor;
    int          nvec = 0;
    int          nerr = 0;

    trial_div_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n        (n),
        .d_max    (d_max),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .factor   (factor),
        .cofactor (cofactor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Latency counts falling edges from the start-driving edge to the one where done is seen.
    task automatic run(input string tag, input logic [31:0] nv, input logic [15:0] dv, input int inj,
                       input logic ef, input logic [15:0] efac, input logic [31:0] ecof, input int elat);
        int cyc = 0;
        @(negedge clk);
        start = 1'b1; n = nv; d_max = dv;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({tag, ".busy1"}, busy, 1'b1);
            start = (cyc == inj);
            if (cyc == inj) n = 32'd6;
        end while (!done && cyc < 5000);
        start = 1'b0;
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".busy_at_done"}, busy, 1'b0);
        chk({tag, ".found"}, found, ef);
        chk({tag, ".factor"}, factor, efac);
        chk({tag, ".cofactor"}, cofactor, ecof);
        if (elat >= 0) chk({tag, ".latency"}, cyc, elat);
        @(negedge clk);
        chk({tag, ".done_pulse"}, done, 1'b0);
        chk({tag, ".found_held"}, found, ef);
        chk({tag, ".factor_held"}, factor, efac);
    endtask

    initial begin
        int nd;
        reset = 1'b1; start = 1'b1; n = 32'd91; d_max = 16'd20;
        repeat (2) @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.found", found, 1'b0);
        chk("rst.factor", factor, 16'd0);
        chk("rst.cofactor", cofactor, 32'd0);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("idle.busy", busy, 1'b0);

        run("n91",  32'd91,  16'd20,  -1, 1'b1, 16'd7, 32'd13, 157);
        run("n97",  32'd97,  16'd20,  -1, 1'b0, 16'd0, 32'd0,  -1);
        run("n5",   32'd5,   16'd100, -1, 1'b0, 16'd0, 32'd0,  12);
        run("n4",   32'd4,   16'd100, -1, 1'b1, 16'd2, 32'd2,  6);
        run("n1",   32'd1,   16'd100, -1, 1'b0, 16'd0, 32'd0,  2);
        run("dm1",  32'd100, 16'd1,   -1, 1'b0, 16'd0, 32'd0,  2);
        run("inj",  32'd91,  16'd20,  10, 1'b1, 16'd7, 32'd13, 157);

        @(negedge clk);
        start = 1'b1; n = 32'd91; d_max = 16'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid.busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.busy", busy, 1'b0);
        chk("abort.done", done, 1'b0);
        chk("abort.found", found, 1'b0);
        reset = 1'b0;
        nd = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort.nodone", nd, 0);
        run("n15", 32'd15, 16'd10, -1, 1'b1, 16'd3, 32'd5, 18);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/trial_div_ctrl.md
TRIAL_DIV_CTRL -- requirements
Module: trial_div_ctrl

Interface
REQ-001 Parameter N_W, default 32: dividend (n) width in bits.
REQ-002 Parameter D_W, default 16: divisor and factor width in bits.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to factor n; sampled only in IDLE.
REQ-006 n  input  N_W  number to factor; latched when start is accepted.
REQ-007 d_max  input  D_W  largest trial divisor; latched when start is accepted.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  single-cycle pulse when the result is valid.
REQ-010 found  output  1  proper factor found; valid with done, held until next accepted start.
REQ-011 factor  output  D_W  smallest proper divisor found; 0 if none.
REQ-012 cofactor  output  N_W  n/factor; 0 if none.

Function
REQ-013 FSM states: IDLE, LOAD, DIVIDE, CHECK, FINISH.
REQ-014 IDLE: start=1 latches n and d_max, clears found/factor/cofactor, and goes to LOAD; start=0 stays in IDLE.
REQ-015 start while not in IDLE is ignored; it has no effect on latched operands or outputs.
REQ-016 LOAD: if n<4 or d_max<2, go to FINISH with found=0; otherwise set the trial divisor d=2, pulse core start, and go to DIVIDE.
REQ-017 Trial divisor counter is D_W+1 bits wide, so d_max=2^D_W-1 terminates without wrap.
REQ-018 DIVIDE: wait for core done; no timeout; latency floor(n/d)+1 cycles from core start to core done.
REQ-019 CHECK, on remainder==0: found=1, factor=d, cofactor=quotient, go to FINISH.
REQ-020 CHECK, otherwise: d=d+1; if d>d_max or d>=n, go to FINISH with found=0; else pulse core start and go to DIVIDE.
REQ-021 FINISH: done=1 for exactly one cycle, then return to IDLE; busy=0 in the cycle done is high.
REQ-022 Divisors are tried strictly ascending, so the first factor found is the smallest prime factor <= d_max.
REQ-023 Divider core: on start it loads rem=n and q=0; each cycle, if rem>=d then rem-=d and q+=1; when rem<d it pulses done with quotient q and remainder rem.
REQ-024 Core arithmetic is unsigned; d is zero-extended to N_W; d=0 never reaches the core.

Reset
REQ-025 reset=1 at a clock edge forces IDLE and sets busy=0, done=0, found=0, factor=0, cofactor=0; the core returns to idle and d=0.
REQ-026 reset mid-operation aborts without a done pulse; busy=0 on the first edge with reset=1.
REQ-027 reset has priority over start in the same cycle.

Structure
REQ-028 The shared package holds the FSM state enum, N_W/D_W defaults, and the constant MIN_N=4.
REQ-029 The repeated-subtraction divider is a separate sub-module, sub_div_core, with ports clk, reset, start, n, d, quotient, remainder, done.
REQ-030 The controller instantiates exactly one sub_div_core and owns the sequencing; it contains no arithmetic beyond the d increment and compares.

Verification
REQ-031 n=91, d_max=20 -> tries 2..7, done with found=1, factor=7, cofactor=13.
REQ-032 n=97, d_max=20 -> tries 2..20, done with found=0, factor=0, cofactor=0.
REQ-033 n=5, d_max=100 -> stops after d=4 (d>=n), found=0; n=4, d_max=100 -> found=1, factor=2, cofactor=2.
REQ-034 n=1 or d_max=1 -> done pulse two cycles after start, found=0, core never started.
REQ-035 start re-pulsed during busy with n=6 while factoring 91 -> ignored, result is still 7/13.
REQ-036 reset asserted mid-DIVIDE -> busy=0 next edge, no done pulse; a following start with n=15, d_max=10 -> factor=3, cofactor=5.
